// File: rtl/multicycle_ctrl_if.sv
// Purpose: bundles the instruction fields, live ALU flags and all datapath
//          control outputs of the multicycle controller.
// Latency: none (wiring only).
// Backpressure: none; the controller has no stall input.
// Ports:   slave  - the controller (consumes instruction/flags, drives controls)
//          master - the datapath side (drives instruction/flags, consumes controls)
interface multicycle_ctrl_if;
    // Instruction fields and live ALU status
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] ALUFlags;

    // Datapath controls
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [3:0] ALUControl;
    logic       CarryIn;
    logic [3:0] Flags;

    modport slave (
        input  Cond, Op, Funct, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
        output ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
        output ALUControl, CarryIn, Flags
    );

    modport master (
        output Cond, Op, Funct, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
        input  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
        input  ALUControl, CarryIn, Flags
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Purpose: Moore-FSM controller for a multicycle ARM-subset datapath, with
//          condition evaluation and the stored NZCV flag register.
// Latency: 2 (cond fail/undef), 3 (branch), 4 (data-proc, STR), 5 (LDR) cycles.
// Backpressure: none; one state per clock, instruction fields held by datapath.
// Ports:   clk, reset (synchronous, active high); bus (slave modport) carries
//          Cond/Op/Funct/ALUFlags in and every control/flag output out.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_e;

    // ALU operation encodings
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_RSB = 4'b0010;
    localparam logic [3:0] ALU_ADC = 4'b0011;
    localparam logic [3:0] ALU_SBC = 4'b0100;
    localparam logic [3:0] ALU_RSC = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_ORR = 4'b1001;
    localparam logic [3:0] ALU_EOR = 4'b1010;
    localparam logic [3:0] ALU_MOV = 4'b1101;
    localparam logic [3:0] ALU_BIC = 4'b1110;
    localparam logic [3:0] ALU_MVN = 4'b1111;

    // Data-processing cmd field values
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_RSB = 4'b0011;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ADC = 4'b0101;
    localparam logic [3:0] CMD_SBC = 4'b0110;
    localparam logic [3:0] CMD_RSC = 4'b0111;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_TEQ = 4'b1001;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_BIC = 4'b1110;
    localparam logic [3:0] CMD_MVN = 4'b1111;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    // Instruction field aliases
    logic [3:0] cmd;
    logic       i_bit;
    logic       s_bit;     // also the L bit for memory instructions
    logic       is_test;   // TST/TEQ/CMP/CMN: set flags, never write a register
    logic       is_arith;  // commands whose flag result includes C and V
    logic       cond_ex;

    assign cmd     = bus.Funct[4:1];
    assign i_bit   = bus.Funct[5];
    assign s_bit   = bus.Funct[0];
    assign is_test = (cmd[3:2] == 2'b10);

    always_comb begin
        is_arith = 1'b0;
        case (cmd)
            CMD_SUB, CMD_RSB, CMD_ADD, CMD_ADC,
            CMD_SBC, CMD_RSC, CMD_CMP, CMD_CMN: is_arith = 1'b1;
            default:                            is_arith = 1'b0;
        endcase
    end

    // Condition check against the stored flags, not the live ALU flags.
    logic flag_n, flag_z, flag_c, flag_v;
    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    always_comb begin
        cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!cond_ex || bus.Op == 2'b11) begin
                    state_d = S_FETCH;
                end else begin
                    case (bus.Op)
                        2'b01:   state_d = S_MEMADR;
                        2'b10:   state_d = S_BRANCH;
                        default: state_d = i_bit ? S_EXECI : S_EXECR;
                    endcase
                end
            end
            S_MEMADR:   state_d = s_bit ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            S_MEMWB,
            S_MEMWRITE,
            S_ALUWB,
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // ALU operation for the execute states
    logic [3:0] alu_dec;
    always_comb begin
        alu_dec = ALU_ADD;
        case (cmd)
            CMD_AND, CMD_TST: alu_dec = ALU_AND;
            CMD_EOR, CMD_TEQ: alu_dec = ALU_EOR;
            CMD_SUB, CMD_CMP: alu_dec = ALU_SUB;
            CMD_RSB:          alu_dec = ALU_RSB;
            CMD_ADD, CMD_CMN: alu_dec = ALU_ADD;
            CMD_ADC:          alu_dec = ALU_ADC;
            CMD_SBC:          alu_dec = ALU_SBC;
            CMD_RSC:          alu_dec = ALU_RSC;
            CMD_ORR:          alu_dec = ALU_ORR;
            CMD_MOV:          alu_dec = ALU_MOV;
            CMD_BIC:          alu_dec = ALU_BIC;
            CMD_MVN:          alu_dec = ALU_MVN;
            default:          alu_dec = ALU_ADD;
        endcase
    end

    // Per-state Moore outputs
    logic       pc_write, ir_write, reg_write, mem_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_control;

    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_control = alu_dec;
            end
            S_EXECI: begin
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
            end
            S_ALUWB: begin
                reg_write = ~is_test;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    // Flag capture at the end of an execute state. Logical ops keep C/V,
    // MOV keeps only V (its C comes from the shifter via the ALU).
    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXECR || state_q == S_EXECI) && (s_bit || is_test)) begin
            if (is_arith) begin
                flags_d = bus.ALUFlags;
            end else if (cmd == CMD_MOV) begin
                flags_d = {bus.ALUFlags[3:1], flags_q[0]};
            end else begin
                flags_d = {bus.ALUFlags[3:2], flags_q[1:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Write enables are suppressed for as long as reset is held.
    assign bus.PCWrite    = pc_write  & ~reset;
    assign bus.IRWrite    = ir_write  & ~reset;
    assign bus.RegWrite   = reg_write & ~reset;
    assign bus.MemWrite   = mem_write & ~reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {(bus.Op == 2'b01), (bus.Op == 2'b10)};
    assign bus.Flags      = flags_q;
    assign bus.CarryIn    = flags_q[1];

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic clk;
    logic reset;

    multicycle_ctrl_if intf ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mw;
        logic       adr;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic [1:0] imm;
        logic [1:0] rsrc;
        logic [3:0] alu;
        logic       cin;
        logic [3:0] fl;
    } rec_t;

    int   total = 0;
    int   bad   = 0;
    int   ncyc;
    bit   chk_en = 1'b0;
    bit   exp_exec = 1'b0;
    rec_t exp_r;
    rec_t act_r;
    logic [3:0] seen_alu;
    logic       seen_cin;

    // Reference state
    logic [3:0] flags_m;
    logic [3:0] cur_cond;
    logic [1:0] cur_op;
    logic [5:0] cur_funct;
    logic [3:0] cur_af;

    // ---------------- behavioural model ----------------
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cc;
            4'h3: return !cc;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cc && !z;
            4'h9: return !cc || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'd0, 4'd8:  return 4'b1000;
            4'd1, 4'd9:  return 4'b1010;
            4'd2, 4'd10: return 4'b0001;
            4'd3:        return 4'b0010;
            4'd4, 4'd11: return 4'b0000;
            4'd5:        return 4'b0011;
            4'd6:        return 4'b0100;
            4'd7:        return 4'b0101;
            4'd12:       return 4'b1001;
            4'd13:       return 4'b1101;
            4'd14:       return 4'b1110;
            default:     return 4'b1111;
        endcase
    endfunction

    function automatic bit is_cmp(input logic [3:0] cmd);
        return (cmd >= 4'd8) && (cmd <= 4'd11);
    endfunction

    function automatic logic [3:0] next_flags(input logic [3:0] f, input logic [5:0] fn,
                                               input logic [3:0] af);
        logic [3:0] cmd;
        cmd = fn[4:1];
        if (!(fn[0] || is_cmp(cmd))) return f;
        if ((cmd >= 4'd2 && cmd <= 4'd7) || cmd == 4'd10 || cmd == 4'd11) return af;
        if (cmd == 4'd13) return {af[3:1], f[0]};
        return {af[3:2], f[1:0]};
    endfunction

    function automatic rec_t base();
        rec_t r;
        r      = '0;
        r.imm  = cur_op;
        r.rsrc = {cur_op == 2'b01, cur_op == 2'b10};
        r.fl   = flags_m;
        r.cin  = flags_m[1];
        return r;
    endfunction

    function automatic rec_t f_fetch();
        rec_t r;
        r = base();
        r.pcw = 1'b1; r.irw = 1'b1; r.sa = 2'b01; r.sb = 2'b10; r.rs = 2'b10;
        return r;
    endfunction

    function automatic rec_t f_decode();
        rec_t r;
        r = base();
        r.sa = 2'b01; r.sb = 2'b10; r.rs = 2'b10;
        return r;
    endfunction

    // One clock of expected behaviour; exec marks the cycle whose closing edge loads flags.
    task automatic step(input rec_t r, input bit exec);
        rec_t g;
        g = r;
        if (reset) begin
            g.pcw = 1'b0; g.irw = 1'b0; g.rw = 1'b0; g.mw = 1'b0;
        end
        exp_r    = g;
        exp_exec = exec;
        @(posedge clk);
        ncyc++;
        if (reset) flags_m = 4'b0000;
        else if (exec) flags_m = next_flags(flags_m, cur_funct, cur_af);
        #1;
    endtask

    task automatic load(input logic [3:0] c, input logic [1:0] op,
                        input logic [5:0] fn, input logic [3:0] af);
        cur_cond = c; cur_op = op; cur_funct = fn; cur_af = af;
        intf.Cond = c; intf.Op = op; intf.Funct = fn; intf.ALUFlags = af;
    endtask

    task automatic run_instr(input logic [3:0] c, input logic [1:0] op,
                             input logic [5:0] fn, input logic [3:0] af, output int n);
        rec_t r;
        bit   ok;
        load(c, op, fn, af);
        ncyc = 0;
        ok = cond_ok(c, flags_m);
        step(f_fetch(), 1'b0);
        step(f_decode(), 1'b0);
        if (ok && op != 2'b11) begin
            case (op)
                2'b01: begin
                    r = base(); r.sb = 2'b01;
                    step(r, 1'b0);
                    if (fn[0]) begin
                        r = base(); r.adr = 1'b1;
                        step(r, 1'b0);
                        r = base(); r.rw = 1'b1; r.rs = 2'b01;
                        step(r, 1'b0);
                    end else begin
                        r = base(); r.adr = 1'b1; r.mw = 1'b1;
                        step(r, 1'b0);
                    end
                end
                2'b10: begin
                    r = base(); r.sb = 2'b01; r.rs = 2'b10; r.pcw = 1'b1;
                    step(r, 1'b0);
                end
                default: begin
                    r = base(); r.sb = fn[5] ? 2'b01 : 2'b00; r.alu = alu_of(fn[4:1]);
                    step(r, 1'b1);
                    r = base(); r.rw = !is_cmp(fn[4:1]);
                    step(r, 1'b0);
                end
            endcase
        end
        n = ncyc;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            act_r.pcw  = intf.PCWrite;
            act_r.irw  = intf.IRWrite;
            act_r.rw   = intf.RegWrite;
            act_r.mw   = intf.MemWrite;
            act_r.adr  = intf.AdrSrc;
            act_r.sa   = intf.ALUSrcA;
            act_r.sb   = intf.ALUSrcB;
            act_r.rs   = intf.ResultSrc;
            act_r.imm  = intf.ImmSrc;
            act_r.rsrc = intf.RegSrc;
            act_r.alu  = intf.ALUControl;
            act_r.cin  = intf.CarryIn;
            act_r.fl   = intf.Flags;
            total++;
            if (act_r !== exp_r) begin
                bad++;
                $display("FAIL cycle_outputs t=%0t: got %h expected %h (cond=%h op=%b funct=%b)",
                         $time, act_r, exp_r, cur_cond, cur_op, cur_funct);
            end
            if (exp_exec) begin
                seen_alu = intf.ALUControl;
                seen_cin = intf.CarryIn;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int   n;
        rec_t r;
        reset = 1'b1;
        load(4'hE, 2'b00, 6'b000000, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        flags_m = 4'b0000;
        chk_en  = 1'b1;
        chk("reset_flags", int'(intf.Flags), 0);
        chk("reset_pcwrite", int'(intf.PCWrite), 0);
        step(f_fetch(), 1'b0);          // still in reset: enables forced low
        reset = 1'b0;

        // ADDS R1,R2,R3
        run_instr(4'hE, 2'b00, 6'b001001, 4'b0110, n);
        chk("adds_cycles", n, 4);
        chk("adds_flags", int'(intf.Flags), 6);
        chk("adds_model_flags", int'(flags_m), 6);

        // CMP then BEQ (taken) then BNE (not taken)
        run_instr(4'hE, 2'b00, 6'b010101, 4'b0100, n);
        chk("cmp_alu", int'(seen_alu), 1);
        chk("cmp_flags", int'(intf.Flags), 4);
        run_instr(4'h0, 2'b10, 6'b000000, 4'b0000, n);
        chk("beq_cycles", n, 3);
        run_instr(4'h1, 2'b10, 6'b000000, 4'b0000, n);
        chk("bne_cycles", n, 2);

        // LDR / STR
        run_instr(4'hE, 2'b01, 6'b000001, 4'b0000, n);
        chk("ldr_cycles", n, 5);
        run_instr(4'hE, 2'b01, 6'b000000, 4'b0000, n);
        chk("str_cycles", n, 4);

        // Undefined op
        run_instr(4'hE, 2'b11, 6'b000000, 4'b0000, n);
        chk("undef_cycles", n, 2);

        // Flags 0011, ANDS keeps C/V, ADC sees carry
        run_instr(4'hE, 2'b00, 6'b001001, 4'b0011, n);
        run_instr(4'hE, 2'b00, 6'b000001, 4'b1000, n);
        chk("ands_flags", int'(intf.Flags), 11);
        chk("ands_model_flags", int'(flags_m), 11);
        run_instr(4'hE, 2'b00, 6'b001010, 4'b0000, n);
        chk("adc_alu", int'(seen_alu), 3);
        chk("adc_carry", int'(seen_cin), 1);

        // Reset asserted in MEMREAD of an LDR
        load(4'hE, 2'b01, 6'b000001, 4'b0000);
        step(f_fetch(), 1'b0);
        step(f_decode(), 1'b0);
        r = base(); r.sb = 2'b01;
        step(r, 1'b0);
        reset = 1'b1;
        r = base(); r.adr = 1'b1;
        step(r, 1'b0);
        step(f_fetch(), 1'b0);
        chk("midreset_flags", int'(intf.Flags), 0);
        reset = 1'b0;
        run_instr(4'hE, 2'b00, 6'b011010, 4'b1010, n);   // MOV: reset FETCH resumes cleanly
        chk("post_reset_mov_cycles", n, 4);

        // Randomized instruction stream
        for (int k = 0; k < 400; k++) begin
            logic [3:0] c;
            logic [1:0] op;
            logic [5:0] fn;
            logic [3:0] af;
            c  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
            op = 2'($urandom_range(0, 3));
            fn = 6'($urandom_range(0, 63));
            af = 4'($urandom_range(0, 15));
            run_instr(c, op, fn, af, n);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port Cond, input, 4, Instr[31:28].
REQ-004 SHALL have port Op, input, 2, Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 SHALL have port Funct, input, 6, Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S for data-processing; [0]=L for memory.
REQ-006 SHALL have port ALUFlags, input, 4, live ALU flags {N,Z,C,V} in bits [3:0].
REQ-007 SHALL have outputs PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, each 1 bit.
REQ-008 SHALL have outputs ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, each 2 bits.
REQ-009 SHALL have output ALUControl, 4 bits, using ALU encoding ADD 0000, SUB 0001, RSB 0010, ADC 0011, SBC 0100, RSC 0101, AND 1000, ORR 1001, EOR 1010, MOV 1101, BIC 1110, MVN 1111.
REQ-010 SHALL have outputs CarryIn, 1 bit (stored C), and Flags, 4 bits (stored NZCV).

Function
REQ-011 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
REQ-012 Transitions SHALL be: FETCH->DECODE; DECODE->FETCH if CondEx=0 or Op=11; DECODE->MEMADR (Op=01), BRANCH (Op=10), EXECI (Op=00, I=1), EXECR (Op=00, I=0); MEMADR->MEMREAD (L=1), MEMWRITE (L=0); MEMREAD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-013 Latency in cycles, FETCH through last state: branch 3, data-processing 4, STR 4, LDR 5, condition-failed or undefined 2.
REQ-014 Per-state outputs SHALL be: FETCH IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ADD; DECODE ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ADD; MEMADR ALUSrcA=00, ALUSrcB=01, ADD; MEMREAD AdrSrc=1, ResultSrc=00; MEMWB RegWrite=1, ResultSrc=01; MEMWRITE AdrSrc=1, MemWrite=1; EXECR ALUSrcA=00, ALUSrcB=00; EXECI ALUSrcA=00, ALUSrcB=01; ALUWB ResultSrc=00, RegWrite=1 unless cmd is TST/TEQ/CMP/CMN; BRANCH ALUSrcA=00, ALUSrcB=01, ResultSrc=10, ADD, PCWrite=1. All unlisted enables SHALL be 0 and selects 00.
REQ-015 In EXECR/EXECI, ALUControl SHALL decode cmd: AND/TST->AND, EOR/TEQ->EOR, SUB/CMP->SUB, RSB->RSB, ADD/CMN->ADD, ADC->ADC, SBC->SBC, RSC->RSC, ORR->ORR, MOV->MOV, BIC->BIC, MVN->MVN. TST/TEQ/CMP/CMN SHALL force flag update regardless of S.
REQ-016 ImmSrc SHALL equal Op; RegSrc[0] SHALL be 1 iff Op=10; RegSrc[1] SHALL be 1 iff Op=01.
REQ-017 CondEx SHALL be evaluated from the stored Flags: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N=V, LT N!=V, GT !Z&(N=V), LE Z|(N!=V), AL 1, 1111 0.
REQ-018 Flags SHALL load on the edge ending EXECR/EXECI when S=1 or cmd is a compare/test: arithmetic cmds load NZCV; logical cmds and MVN load N,Z only; MOV loads N,Z,C; unlisted bits SHALL be retained.
REQ-019 CarryIn SHALL equal Flags[1] combinationally in every state.
REQ-020 A failed condition SHALL produce no RegWrite, MemWrite, or branch PCWrite; only the FETCH PC increment occurs.

Reset
REQ-021 While reset=1 at an edge, state SHALL become FETCH and Flags SHALL become 0000, including mid-instruction.
REQ-022 While reset is high, all write enables SHALL be forced to 0; on the first cycle after reset deasserts, FETCH outputs are driven.

Verification
REQ-023 ADDS R1,R2,R3, Cond=1110, Funct=001001, ALUFlags=0110 in EXECR -> states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 in ALUWB; Flags=0110.
REQ-024 CMP, cmd=1010, S=1, ALUFlags=0100 -> ALUControl=0001; Flags=0100; RegWrite=0 in ALUWB; next BEQ (Cond=0000, Op=10) -> BRANCH with PCWrite=1.
REQ-025 BNE, Cond=0001, with Flags Z=1 -> DECODE->FETCH; 2 cycles; PCWrite high only in FETCH.
REQ-026 LDR, Op=01, L=1 -> 5 states ending MEMWB with RegWrite=1 and ResultSrc=01; STR -> MEMWRITE with MemWrite=1 and AdrSrc=1.
REQ-027 ANDS with Flags=0011 and ALUFlags=1000 -> Flags=1011 (C and V retained); next ADC -> ALUControl=0011 and CarryIn=1.
REQ-028 Reset asserted during MEMREAD -> next state FETCH; Flags=0000; MemWrite and RegWrite stay 0 throughout.
